spi_reg_bank: RTL
=================

// Module: spi_reg_bank
// PURPOSE
//  Parametrised SPI slave (mode 0, MSB first) giving the PIC access to an FPGA register bank.
//  Generalises the fixed single-word SPI register block: configurable address/data width,
//  N_WR read/write control registers, N_RD read-only status inputs, burst auto-increment,
//  per-register write strobes and a frame-error counter. Sits between the PIC SPI pins and core logic.
// PARAMETERS
//  ADDR_W    7    address field width (frame header = 1 W-flag bit + ADDR_W bits)
//  DATA_W    16   data word width
//  N_WR      4    R/W registers at addresses 0..N_WR-1
//  N_RD      8    read-only inputs at addresses RD_BASE..RD_BASE+N_RD-1
//  RD_BASE   16   base address of read-only window (must be >= N_WR)
//  BURST_EN  1    1: address auto-increments per word while CS low; 0: address held
// PORTS
//  theClock     in   1             system clock, >= 8x SPI clock
//  theReset_n   in   1             asynchronous active-low reset
//  spi_clk      in   1             SPI clock (async, double-synchronised)
//  spi_cs_n     in   1             SPI chip select, active low (async, double-synchronised)
//  spi_sdi      in   1             MOSI (async, double-synchronised)
//  spi_sdo      out  1             MISO = MSB of shift register
//  rd_regs      in   N_RD*DATA_W   read-only inputs, word k at [k*DATA_W +: DATA_W]
//  wr_regs      out  N_WR*DATA_W   R/W register contents, same packing
//  wr_strobe    out  N_WR          1-cycle pulse on register k commit
//  busy         out  1             high while a frame is in progress (state != IDLE)
//  frame_err    out  8             saturating count of aborted words
// BEHAVIOUR
//  Reset (async, theReset_n=0): state IDLE; wr_regs=0; wr_strobe=0; busy=0; frame_err=0;
//   shift reg=0 (spi_sdo=0); bit counter and address cleared. Mid-frame reset drops the frame, no commit.
//  Sync: spi_clk/cs_n/sdi each pass 2 flops; rising edge = sync clk 0->1; sdi sampled from its sync stage.
//  FSM: IDLE -> (cs low) ADDR -> (1+ADDR_W rising edges) LOAD -> DATA -> (DATA_W rising edges) COMMIT
//   -> LOAD (next word, cs still low). CS high in any state -> IDLE next cycle (overrides all).
//  ADDR: header shifted in MSB first; first bit = W flag, then address MSB..LSB.
//  LOAD (1 cycle): shift reg <= word at current address: wr_regs[k] for 0..N_WR-1,
//   rd_regs[k] for RD_BASE..RD_BASE+N_RD-1, else all zeros. Snapshot; later input changes not seen.
//  DATA: each rising edge: shift reg <= {shift[DATA_W-2:0], sdi}; counter++.
//  COMMIT (1 cycle): if W=1 and addr < N_WR: wr_regs[addr] <= shift reg, wr_strobe[addr]=1 this
//   cycle only. W=1 to read-only/unmapped address: silently ignored, no strobe.
//   Then if BURST_EN addr <= addr+1 (wraps mod 2^ADDR_W); read frames also auto-increment.
//  Abort: CS rises with 0 < bit count < DATA_W in DATA, or during ADDR after >=1 bit:
//   partial word discarded, no commit, frame_err += 1 (saturates at 255). CS rise at word
//   boundary (after COMMIT, in LOAD) is a normal end, not an error.
//  Simultaneous CS rise and final data edge: CS wins -> abort counted, no commit.
//  Latency: wr_regs update 1 theClock after the word's last sync'd rising edge (+2 sync cycles).
//  spi_sdo changes only on LOAD and shift cycles; master samples on next SPI rising edge.
// TESTING
//  Read: rd_regs[0]=16'hA5C3, frame W=0 addr=16, 16 clocks -> spi_sdo serialises A5C3, no strobe.
//  Write: W=1 addr=1 data=16'h1234 -> wr_regs[1]=1234, wr_strobe=4'b0010 one cycle, others unchanged.
//  Burst: W=1 addr=0 data 0001,0002,0003 in one CS -> wr_regs[0..2]=1,2,3, three single strobes.
//  Abort: W=1 addr=2, CS high after 9 data bits -> wr_regs[2] unchanged, frame_err=1, busy=0.
//  Unmapped/RO: read addr=8 -> sdo all 0; write addr=16 -> no strobe, no change.
//  Reset mid-frame: theReset_n low during DATA -> all outputs reset values, next frame works normally.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave giving the PIC access to a bank of R/W control registers
// and read-only status words, with burst auto-increment and frame-error counting.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | CS high, waiting for a frame
// ADDR   | shifting in W flag + address, MSB first
// LOAD   | snapshot word at current address into the shift register
// DATA   | shifting data in on sdi / out on sdo
// COMMIT | word complete: write if allowed, advance address
module spi_reg_bank #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 16,
    parameter int N_WR     = 4,
    parameter int N_RD     = 8,
    parameter int RD_BASE  = 16,
    parameter bit BURST_EN = 1'b1
) (
    input  logic                     theClock,
    input  logic                     theReset_n,
    input  logic                     spi_clk,
    input  logic                     spi_cs_n,
    input  logic                     spi_sdi,
    output logic                     spi_sdo,
    input  logic [N_RD*DATA_W-1:0]   rd_regs,
    output logic [N_WR*DATA_W-1:0]   wr_regs,
    output logic [N_WR-1:0]          wr_strobe,
    output logic                     busy,
    output logic [7:0]               frame_err
);

    localparam int CNT_W = $clog2(DATA_W + ADDR_W + 2);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_DATA, S_COMMIT} state_t;

    state_t              state, state_nxt;
    logic [1:0]          clk_sync, cs_sync, sdi_sync;
    logic                clk_prev;
    logic                spi_rise, cs_high, sdi_bit;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W:0]     hdr, hdr_nxt;
    logic [ADDR_W-1:0]   addr;
    logic                w_flag;
    logic [DATA_W-1:0]   shift_reg, load_word;
    logic                abort;

    // CS synchroniser resets to the deasserted level so reset never looks like a frame start
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            clk_sync <= 2'b00;
            cs_sync  <= 2'b11;
            sdi_sync <= 2'b00;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], spi_clk};
            cs_sync  <= {cs_sync[0], spi_cs_n};
            sdi_sync <= {sdi_sync[0], spi_sdi};
            clk_prev <= clk_sync[1];
        end
    end

    assign spi_rise = clk_sync[1] & ~clk_prev;
    assign cs_high  = cs_sync[1];
    assign sdi_bit  = sdi_sync[1];
    assign hdr_nxt  = {hdr[ADDR_W-1:0], sdi_bit};
    assign spi_sdo  = shift_reg[DATA_W-1];

    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_high) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_ADDR;
                S_ADDR:   if (spi_rise && bit_cnt == CNT_W'(ADDR_W)) state_nxt = S_LOAD;
                S_LOAD:   state_nxt = S_DATA;
                S_DATA:   if (spi_rise && bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = S_COMMIT;
                S_COMMIT: state_nxt = S_LOAD;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        abort     = cs_high && (state == S_ADDR || state == S_DATA) && (bit_cnt != '0);
        wr_strobe = '0;
        if (state == S_COMMIT && w_flag) begin
            for (int k = 0; k < N_WR; k++)
                if (addr == ADDR_W'(k)) wr_strobe[k] = 1'b1;
        end
    end

    always_comb begin
        load_word = '0;
        for (int k = 0; k < N_WR; k++)
            if (addr == ADDR_W'(k)) load_word = wr_regs[k*DATA_W +: DATA_W];
        for (int k = 0; k < N_RD; k++)
            if (addr == ADDR_W'(RD_BASE + k)) load_word = rd_regs[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            shift_reg <= '0;
            hdr       <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            w_flag    <= 1'b0;
            wr_regs   <= '0;
            frame_err <= '0;
        end else begin
            if (abort && frame_err != 8'hFF) frame_err <= frame_err + 8'd1;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    hdr     <= '0;
                end
                S_ADDR: if (spi_rise) begin
                    hdr     <= hdr_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(ADDR_W)) begin
                        w_flag <= hdr_nxt[ADDR_W];
                        addr   <= hdr_nxt[ADDR_W-1:0];
                    end
                end
                S_LOAD: begin
                    shift_reg <= load_word;
                    bit_cnt   <= '0;
                end
                S_DATA: if (spi_rise) begin
                    shift_reg <= {shift_reg[DATA_W-2:0], sdi_bit};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                S_COMMIT: begin
                    for (int k = 0; k < N_WR; k++)
                        if (wr_strobe[k]) wr_regs[k*DATA_W +: DATA_W] <= shift_reg;
                    if (BURST_EN) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
